// File: rtl/edm_pkg.sv
// Shared EDM definitions: one-hot sequencer states seen by the breakdown
// detector, and default pulse timing constants.
package edm_pkg;

    localparam logic [7:0] S_WAIT_BREAKDOWN = 8'b00000001;
    localparam logic [7:0] S_DISCHARGE      = 8'b00000010;
    localparam logic [7:0] S_DEION          = 8'b00000100;
    localparam logic [7:0] S_SHORT          = 8'b00001000;
    localparam logic [7:0] S_IDLE           = 8'b00010000;

    localparam logic [15:0] DEF_WAIT_TIMEOUT         = 16'd5000;
    localparam logic [15:0] DEF_SHORT_THRESHOLD_VOL  = 16'd5;
    localparam logic [15:0] DEF_SHORT_THRESHOLD_TIME = 16'd20;
    localparam logic [15:0] DEF_SHORT_HOLD_TIME      = 16'd10000;

    // The MOSFET conducts only while waiting for breakdown or discharging.
    function automatic logic gate_state(input logic [7:0] st);
        return (st == S_WAIT_BREAKDOWN) || (st == S_DISCHARGE);
    endfunction

endpackage

// File: rtl/edm_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones
// instead of wrapping.
module edm_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/discharge_pulse_fsm.sv
// Per-pulse EDM sequencer: wait for breakdown, timed Ton discharge, Toff
// deionisation, with open-gap timeout and short-circuit hold-off.
module discharge_pulse_fsm #(
    parameter logic [15:0] WAIT_TIMEOUT         = edm_pkg::DEF_WAIT_TIMEOUT,
    parameter logic [15:0] SHORT_THRESHOLD_VOL  = edm_pkg::DEF_SHORT_THRESHOLD_VOL,
    parameter logic [15:0] SHORT_THRESHOLD_TIME = edm_pkg::DEF_SHORT_THRESHOLD_TIME,
    parameter logic [15:0] SHORT_HOLD_TIME      = edm_pkg::DEF_SHORT_HOLD_TIME
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               discharge_en,
    input  logic [15:0]        ton_cycles,
    input  logic [15:0]        toff_cycles,
    input  logic signed [15:0] sample_voltage,
    input  logic               is_breakdown,
    output logic [7:0]         current_state,
    output logic               gate_on,
    output logic               pulse_done,
    output logic               open_timeout,
    output logic               short_flag,
    output logic [15:0]        ignition_delay
);

    import edm_pkg::*;

    localparam int CNT_PHASE = 0;
    localparam int CNT_WAIT  = 1;
    localparam int CNT_SHORT = 2;
    localparam int NUM_CNT   = 3;

    logic [7:0]  state_reg, state_next;
    logic [15:0] ton_reg, ton_next;
    logic [15:0] toff_reg, toff_next;
    logic [15:0] ignition_delay_reg, ignition_delay_next;
    logic        pulse_done_reg, pulse_done_next;
    logic        open_timeout_reg, open_timeout_next;
    logic        short_flag_reg, short_flag_next;

    logic [NUM_CNT-1:0] cnt_clr;
    logic [15:0]        cnt_val [NUM_CNT];

    logic start_ok;
    logic shorted;

    assign start_ok = discharge_en && (ton_cycles != 16'd0) && (toff_cycles != 16'd0);
    assign shorted  = (sample_voltage <= $signed(SHORT_THRESHOLD_VOL));

    // Phase counter restarts on every state change, so it reads 0 on the
    // first cycle of DISCHARGE, DEION and SHORT.
    assign cnt_clr[CNT_PHASE] = (state_next != state_reg);
    assign cnt_clr[CNT_WAIT]  = (state_reg != S_WAIT_BREAKDOWN);
    assign cnt_clr[CNT_SHORT] = (state_reg != S_WAIT_BREAKDOWN) || !shorted;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            edm_sat_counter #(
                .WIDTH(16)
            ) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (cnt_clr[gi]),
                .en   (1'b1),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next          = state_reg;
        ton_next            = ton_reg;
        toff_next           = toff_reg;
        ignition_delay_next = ignition_delay_reg;
        pulse_done_next     = 1'b0;
        open_timeout_next   = 1'b0;
        short_flag_next     = short_flag_reg;

        case (state_reg)
            S_IDLE: begin
                if (!discharge_en) begin
                    short_flag_next = 1'b0;
                end
                if (start_ok) begin
                    ton_next   = ton_cycles;
                    toff_next  = toff_cycles;
                    state_next = S_WAIT_BREAKDOWN;
                end
            end
            S_WAIT_BREAKDOWN: begin
                if (!discharge_en) begin
                    state_next = S_DEION;
                end else if (is_breakdown) begin
                    ignition_delay_next = cnt_val[CNT_WAIT];
                    state_next          = S_DISCHARGE;
                end else if (shorted && (cnt_val[CNT_SHORT] == SHORT_THRESHOLD_TIME - 16'd1)) begin
                    short_flag_next = 1'b1;
                    state_next      = S_SHORT;
                end else if (cnt_val[CNT_WAIT] == WAIT_TIMEOUT - 16'd1) begin
                    open_timeout_next = 1'b1;
                    state_next        = S_DEION;
                end
            end
            S_DISCHARGE: begin
                if (!discharge_en) begin
                    state_next = S_DEION;
                end else if (cnt_val[CNT_PHASE] == ton_reg - 16'd1) begin
                    pulse_done_next = 1'b1;
                    state_next      = S_DEION;
                end
            end
            S_DEION: begin
                if (cnt_val[CNT_PHASE] == toff_reg - 16'd1) begin
                    if (start_ok) begin
                        ton_next   = ton_cycles;
                        toff_next  = toff_cycles;
                        state_next = S_WAIT_BREAKDOWN;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_SHORT: begin
                if (cnt_val[CNT_PHASE] == SHORT_HOLD_TIME - 16'd1) begin
                    state_next = S_DEION;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            ton_reg            <= 16'd0;
            toff_reg           <= 16'd0;
            ignition_delay_reg <= 16'd0;
            pulse_done_reg     <= 1'b0;
            open_timeout_reg   <= 1'b0;
            short_flag_reg     <= 1'b0;
        end else begin
            state_reg          <= state_next;
            ton_reg            <= ton_next;
            toff_reg           <= toff_next;
            ignition_delay_reg <= ignition_delay_next;
            pulse_done_reg     <= pulse_done_next;
            open_timeout_reg   <= open_timeout_next;
            short_flag_reg     <= short_flag_next;
        end
    end

    assign current_state  = state_reg;
    assign gate_on        = gate_state(state_reg);
    assign pulse_done     = pulse_done_reg;
    assign open_timeout   = open_timeout_reg;
    assign short_flag     = short_flag_reg;
    assign ignition_delay = ignition_delay_reg;

endmodule

// File: tb/tb_discharge_pulse_fsm.sv
// Directed bench for discharge_pulse_fsm: start-condition table plus
// hand-written multi-cycle pulse sequences.
module tb_discharge_pulse_fsm;

    localparam logic [7:0] S_WAIT = 8'b00000001;
    localparam logic [7:0] S_DIS  = 8'b00000010;
    localparam logic [7:0] S_DEI  = 8'b00000100;
    localparam logic [7:0] S_SHT  = 8'b00001000;
    localparam logic [7:0] S_IDL  = 8'b00010000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               discharge_en = 1'b0;
    logic [15:0]        ton_cycles = 16'd0;
    logic [15:0]        toff_cycles = 16'd0;
    logic signed [15:0] sample_voltage = 16'sd100;
    logic               is_breakdown = 1'b0;
    logic [7:0]         current_state;
    logic               gate_on;
    logic               pulse_done;
    logic               open_timeout;
    logic               short_flag;
    logic [15:0]        ignition_delay;

    int checks = 0;
    int errors = 0;
    int gate_acc;
    int n, pd, ot;

    always #5 clk = ~clk;

    discharge_pulse_fsm #(
        .WAIT_TIMEOUT(16'd50)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .discharge_en  (discharge_en),
        .ton_cycles    (ton_cycles),
        .toff_cycles   (toff_cycles),
        .sample_voltage(sample_voltage),
        .is_breakdown  (is_breakdown),
        .current_state (current_state),
        .gate_on       (gate_on),
        .pulse_done    (pulse_done),
        .open_timeout  (open_timeout),
        .short_flag    (short_flag),
        .ignition_delay(ignition_delay)
    );

    typedef struct {
        logic        en;
        logic [15:0] ton;
        logic [15:0] toff;
        logic [7:0]  exp_state;
        logic        exp_gate;
    } start_vec_t;

    start_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts cycles spent in state st (bounded), accumulating strobes and gate.
    task automatic count_state(input logic [7:0] st, input int limit,
                               output int cyc, output int pds, output int ots);
        cyc = 0;
        pds = 0;
        ots = 0;
        while (current_state == st && cyc < limit) begin
            cyc++;
            pds += int'(pulse_done);
            ots += int'(open_timeout);
            gate_acc += int'(gate_on);
            tick();
        end
    endtask

    task automatic go_idle(input string name);
        int k;
        discharge_en = 1'b0;
        k = 0;
        while (current_state != S_IDL && k < 20000) begin
            k++;
            tick();
        end
        check(name, current_state, S_IDL);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'd0, 16'd3, S_IDL, 1'b0};
        vecs[1] = '{1'b1, 16'd5, 16'd0, S_IDL, 1'b0};
        vecs[2] = '{1'b0, 16'd5, 16'd3, S_IDL, 1'b0};
        vecs[3] = '{1'b1, 16'd5, 16'd3, S_WAIT, 1'b1};
        vecs[4] = '{1'b1, 16'd1, 16'd1, S_WAIT, 1'b1};

        // Reset state
        #12;
        check("reset_state", current_state, S_IDL);
        check("reset_gate", gate_on, 1'b0);
        check("reset_flags", {pulse_done, open_timeout, short_flag}, 3'b000);
        check("reset_ign", ignition_delay, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start-condition table
        for (int i = 0; i < 5; i++) begin
            discharge_en = vecs[i].en;
            ton_cycles   = vecs[i].ton;
            toff_cycles  = vecs[i].toff;
            tick();
            tick();
            check($sformatf("start%0d_state", i), current_state, vecs[i].exp_state);
            check($sformatf("start%0d_gate", i), gate_on, vecs[i].exp_gate);
            if (current_state != S_IDL) go_idle($sformatf("start%0d_idle", i));
        end

        // Normal pulse: breakdown 37 cycles into WAIT, ton=100, toff=200
        discharge_en = 1'b1;
        ton_cycles   = 16'd100;
        toff_cycles  = 16'd200;
        tick();
        check("p1_wait", current_state, S_WAIT);
        gate_acc = 0;
        for (int i = 0; i < 37; i++) begin
            gate_acc += int'(gate_on);
            tick();
        end
        gate_acc += int'(gate_on);
        is_breakdown = 1'b1;
        tick();
        is_breakdown = 1'b0;
        ton_cycles   = 16'd5;
        check("p1_dis", current_state, S_DIS);
        check("p1_ign", ignition_delay, 16'd37);
        count_state(S_DIS, 500, n, pd, ot);
        check("p1_ton_cycles", n, 100);
        check("p1_gate_total", gate_acc, 138);
        ton_cycles = 16'd100;
        check("p1_deion", current_state, S_DEI);
        count_state(S_DEI, 1000, n, pd, ot);
        check("p1_toff_cycles", n, 200);
        check("p1_pulse_done", pd, 1);
        check("p1_rewait", current_state, S_WAIT);

        // Open-gap timeout
        gate_acc = 0;
        count_state(S_WAIT, 1000, n, pd, ot);
        check("to_wait_cycles", n, 50);
        check("to_state", current_state, S_DEI);
        check("to_strobe", open_timeout, 1'b1);
        check("to_gate", gate_on, 1'b0);
        count_state(S_DEI, 1000, n, pd, ot);
        check("to_toff_cycles", n, 200);
        check("to_strobe_once", ot, 1);
        check("to_no_pulse_done", pd, 0);
        go_idle("to_idle");

        // Short circuit
        discharge_en   = 1'b1;
        ton_cycles     = 16'd100;
        toff_cycles    = 16'd50;
        sample_voltage = 16'sd2;
        tick();
        count_state(S_WAIT, 1000, n, pd, ot);
        check("sh_wait_cycles", n, 20);
        check("sh_state", current_state, S_SHT);
        check("sh_flag", short_flag, 1'b1);
        check("sh_gate", gate_on, 1'b0);
        gate_acc = 0;
        count_state(S_SHT, 20000, n, pd, ot);
        check("sh_hold_cycles", n, 10000);
        check("sh_hold_gate", gate_acc, 0);
        check("sh_to_deion", current_state, S_DEI);
        discharge_en   = 1'b0;
        sample_voltage = 16'sd100;
        count_state(S_DEI, 1000, n, pd, ot);
        check("sh_toff_cycles", n, 50);
        check("sh_flag_sticky", short_flag, 1'b1);
        check("sh_idle", current_state, S_IDL);
        tick();
        check("sh_flag_clear", short_flag, 1'b0);

        // Breakdown and short threshold on the same cycle
        discharge_en   = 1'b1;
        sample_voltage = 16'sd2;
        tick();
        for (int i = 0; i < 19; i++) tick();
        is_breakdown = 1'b1;
        tick();
        is_breakdown   = 1'b0;
        sample_voltage = 16'sd100;
        check("tie_state", current_state, S_DIS);
        check("tie_flag", short_flag, 1'b0);
        check("tie_ign", ignition_delay, 16'd19);

        // Enable drop at discharge cycle 40
        for (int i = 0; i < 40; i++) tick();
        discharge_en = 1'b0;
        tick();
        check("drop_state", current_state, S_DEI);
        count_state(S_DEI, 1000, n, pd, ot);
        check("drop_toff_cycles", n, 50);
        check("drop_no_pulse_done", pd, 0);
        check("drop_idle", current_state, S_IDL);

        // Asynchronous reset mid-WAIT
        discharge_en = 1'b1;
        tick();
        tick();
        check("rst_pre_gate", gate_on, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gate", gate_on, 1'b0);
        check("rst_state", current_state, S_IDL);
        check("rst_ign", ignition_delay, 16'd0);
        discharge_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_after", current_state, S_IDL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
